wb_alu_responder: RTL and testbench
===================================

Name: wb_alu_responder

Overview:
- Wishbone classic slave that lets the management SoC drive the dual-ALU/XOR function from firmware instead of from io_in pins.
- Firmware writes operands and op selects, then pulses START. The block snapshots the operands and runs a fixed-latency computation.
- Results are captured in a readable register; a done flag and an optional interrupt are raised on completion.
- Sits inside a user macro, on the wbs_* port group and one user_irq bit.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the 16-byte register window; must be 16-byte aligned.
- LATENCY, 4, cycles from START accept to result capture; legal range 1..15.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_stb_i  in  1  strobe.
- wbs_cyc_i  in  1  bus cycle.
- wbs_we_i  in  1  1=write.
- wbs_sel_i  in  4  byte enables.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  byte address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- irq_o  out  1  level interrupt, intended for user_irq[0].

Behaviour:
- Registers (offset = adr[3:2]):
  - 0x0 OPER, RW: [7:0] A0, [15:8] B0, [23:16] A1, [31:24] B1.
  - 0x4 CTRL, RW: [1:0] SEL1, [3:2] SEL2, [4] IRQ_EN. Bit [8] START is write-only and always reads 0. Other bits read 0.
  - 0x8 STAT: [0] BUSY (RO), [1] DONE (W1C), [2] OVERRUN (W1C). Other bits read 0.
  - 0xC RES, RO: [7:0] OUT1, [15:8] OUT2, [16] C1, [17] C2, [25:18] X, [26] Y.
- Decode and acknowledge:
  - Hit when adr[31:4]==BASE_ADDR[31:4] and cyc&stb.
  - ack_o is registered: asserts exactly one cycle after cyc&stb is seen with ack_o low. It is high for one cycle only, then low for at least one cycle even if stb stays high.
  - Miss (address outside the window) is still acked, returns 0, and ignores writes. The bus never hangs.
  - wbs_dat_o is valid in the ack cycle and 0 otherwise.
  - Writes honour wbs_sel_i per byte; START needs sel[1]. A W1C bit clears only if its byte is selected.
- ALU (per pair; pair 1 = A0/B0/SEL1 -> OUT1/C1, pair 2 = A1/B1/SEL2 -> OUT2/C2):
  - SEL 00: A+B mod 256, C = bit 8 of the 9-bit sum.
  - SEL 01: A-B mod 256, C = 1 if A<B (borrow).
  - SEL 10: A&B, C = 0.
  - SEL 11: A|B, C = 0.
  - X = OUT1^OUT2; Y = XOR-reduction of X.
- FSM:
  - IDLE: a START write with BUSY=0 accepts in the ack cycle. It snapshots OPER, SEL1 and SEL2, sets BUSY, clears DONE, loads counter=LATENCY-1, and moves to RUN.
  - RUN: counter decrements each cycle. At counter==0, RES is written from the snapshot, BUSY clears, DONE sets, and the FSM returns to IDLE.
  - RES, DONE and BUSY change at cycle N+LATENCY, where N is the START ack cycle.
- START while BUSY=1: ignored, no restart; OVERRUN sets.
- OPER/CTRL writes during RUN: take effect in the registers but do not affect the in-flight result (it uses the snapshot).
- W1C on DONE in the same cycle as completion: set wins.
- irq_o = DONE & IRQ_EN, combinational from registers. Clearing DONE or IRQ_EN deasserts it the next cycle.
- RES holds its last value until the next completion.
- Reset values: all registers 0, FSM IDLE, counter 0, ack_o 0, wbs_dat_o 0, irq_o 0.
- Reset mid-RUN: the operation is aborted; RES stays 0; no DONE.

Test Plan:
- Reset then read all 4 regs -> each returns 32'h0; ack_o is a single-cycle pulse per access; irq_o=0.
- OPER=32'h0A_05_C8_64 (A0=0x64, B0=0xC8, A1=0x05, B1=0x0A), CTRL=SEL1 00, SEL2 01, START -> BUSY=1 for exactly LATENCY cycles, then RES: OUT1=0x2C, C1=1, OUT2=0xFB, C2=1, X=0xD7, Y=0; DONE=1.
- OPER=32'h0F_3C_F0_AA, SEL1=10, SEL2=11, IRQ_EN=1, START -> OUT1=0xA0, OUT2=0x3F, C1=C2=0, X=0x9F, Y=0; irq_o rises with DONE. Write STAT=0x2 -> DONE=0, irq_o=0 next cycle.
- START, then START again 1 cycle later, plus an OPER rewrite mid-RUN -> single completion with the original-operand result; OVERRUN=1; clears via W1C 0x4.
- Write to BASE_ADDR+0x10 and read back -> acked, read 0, no register changes. Write OPER with sel=4'b0010 data 32'hFFFF_FFFF over 0 -> OPER=32'h0000_FF00.
- Assert wb_rst_i for 1 cycle mid-RUN -> BUSY=0, DONE=0, RES=0, and no late completion afterwards.

Source files
------------

// File: rtl/wb_alu_responder.sv
// Wishbone classic slave wrapping the dual-ALU/XOR function: firmware loads operands,
// pulses START, and reads the result after a fixed latency.
module wb_alu_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] oper_q, oper_d;
  logic [4:0]  ctrl_q, ctrl_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic [26:0] res_q, res_d;
  logic [31:0] snap_oper_q, snap_oper_d;
  logic [3:0]  snap_sel_q, snap_sel_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;

  logic        req, hit, wr;
  logic [1:0]  offs;
  logic        start_wr;
  logic [8:0]  r1, r2;
  logic [7:0]  x;
  logic        unused_ok;

  assign unused_ok = ^wbs_adr_i[1:0];

  function automatic logic [8:0] alu(input logic [7:0] a, input logic [7:0] b,
                                     input logic [1:0] sel);
    case (sel)
      2'b00:   alu = {1'b0, a} + {1'b0, b};
      2'b01:   alu = {1'b0, a} - {1'b0, b};  // bit 8 is the borrow
      2'b10:   alu = {1'b0, a & b};
      default: alu = {1'b0, a | b};
    endcase
  endfunction

  always_comb begin
    req      = wbs_cyc_i & wbs_stb_i & ~ack_q;
    hit      = req & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    wr       = hit & wbs_we_i;
    offs     = wbs_adr_i[3:2];
    start_wr = wr & (offs == 2'd1) & wbs_sel_i[1] & wbs_dat_i[8];

    r1 = alu(snap_oper_q[7:0],   snap_oper_q[15:8],  snap_sel_q[1:0]);
    r2 = alu(snap_oper_q[23:16], snap_oper_q[31:24], snap_sel_q[3:2]);
    x  = r1[7:0] ^ r2[7:0];

    state_d     = state_q;
    cnt_d       = cnt_q;
    oper_d      = oper_q;
    ctrl_d      = ctrl_q;
    done_d      = done_q;
    ovr_d       = ovr_q;
    res_d       = res_q;
    snap_oper_d = snap_oper_q;
    snap_sel_d  = snap_sel_q;
    ack_d       = req;
    dat_d       = 32'h0;

    if (hit && !wbs_we_i) begin
      case (offs)
        2'd0:    dat_d = oper_q;
        2'd1:    dat_d = {27'h0, ctrl_q};
        2'd2:    dat_d = {29'h0, ovr_q, done_q, state_q == S_RUN};
        default: dat_d = {5'h0, res_q};
      endcase
    end

    if (wr) begin
      case (offs)
        2'd0: for (int i = 0; i < 4; i++)
                if (wbs_sel_i[i]) oper_d[8*i +: 8] = wbs_dat_i[8*i +: 8];
        2'd1: if (wbs_sel_i[0]) ctrl_d = wbs_dat_i[4:0];
        2'd2: if (wbs_sel_i[0]) begin
                if (wbs_dat_i[1]) done_d = 1'b0;
                if (wbs_dat_i[2]) ovr_d  = 1'b0;
              end
        default: ;
      endcase
    end

    // FSM updates come after the bus writes so completion beats a same-cycle W1C
    case (state_q)
      S_IDLE: begin
        if (start_wr) begin
          snap_oper_d = oper_q;
          snap_sel_d  = ctrl_d[3:0];
          cnt_d       = 4'(LATENCY - 1);
          done_d      = 1'b0;
          state_d     = S_RUN;
        end
      end
      default: begin
        if (start_wr) ovr_d = 1'b1;
        if (cnt_q == 4'd0) begin
          res_d   = {^x, x, r2[8], r1[8], r2[7:0], r1[7:0]};
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'h0;
      oper_q      <= 32'h0;
      ctrl_q      <= 5'h0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      res_q       <= 27'h0;
      snap_oper_q <= 32'h0;
      snap_sel_q  <= 4'h0;
      ack_q       <= 1'b0;
      dat_q       <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      oper_q      <= oper_d;
      ctrl_q      <= ctrl_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      res_q       <= res_d;
      snap_oper_q <= snap_oper_d;
      snap_sel_q  <= snap_sel_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = done_q & ctrl_q[4];

endmodule

// File: tb/tb_wb_alu_responder.sv
// Self-checking bench for wb_alu_responder: vector table for ALU results plus
// hand sequences for ack timing, overrun, window misses and reset mid-run.
module tb_wb_alu_responder;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int LAT = 6;
  localparam logic [31:0] A_OPER = BASE + 32'h0;
  localparam logic [31:0] A_CTRL = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_RES  = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_i = 32'h0, adr = 32'h0;
  logic        ack, irq;
  logic [31:0] dat_o;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [31:0] oper;
    logic [4:0]  ctrl;
    logic [7:0]  o1, o2;
    logic        c1, c2;
  } vec_t;
  vec_t vecs[5];

  wb_alu_responder #(.BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc),
    .wbs_we_i(we), .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
    .wbs_ack_o(ack), .wbs_dat_o(dat_o), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_res(input vec_t v);
    logic [7:0] x;
    x = v.o1 ^ v.o2;
    return {5'b0, ^x, x, v.c2, v.c1, v.o2, v.o1};
  endfunction

  // One classic cycle; returns in the ack cycle, 1 ns after the edge
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    int n;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 20);
    if (!ack) begin
      failures++;
      $display("FAIL bus_timeout: no ack for adr 0x%08h after %0d cycles", a, n);
    end
    rd = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] rd;
    bus(1'b1, a, d, s, rd);
  endtask

  task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    sb_t e;
    sb_q.push_back('{exp: exp, name: name});
    bus(1'b0, a, 32'h0, 4'hF, rd);
    e = sb_q.pop_front();
    check(e.name, rd, e.exp);
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] rd;
    int n;
    n = 0;
    do begin
      bus(1'b0, A_STAT, 32'h0, 4'hF, rd);
      n++;
    end while (rd[0] && n < 50);
    if (rd[0]) begin
      failures++;
      $display("FAIL %s: BUSY still 1 after %0d polls", name, n);
    end
  endtask

  initial begin
    logic [5:0] ack_pat;
    int n;

    vecs[0] = '{32'h0A05_C864, 5'h04, 8'h2C, 8'hFB, 1'b1, 1'b1};
    vecs[1] = '{32'h0F3C_F0AA, 5'h1E, 8'hA0, 8'h3F, 1'b0, 1'b0};
    vecs[2] = '{32'h01FF_5555, 5'h01, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{32'h7F80_0100, 5'h01, 8'hFF, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{32'h07FF_3412, 5'h0B, 8'h36, 8'h07, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("reset_ack", {31'h0, ack}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    rd_chk(A_OPER, 32'h0, "reset_oper");
    rd_chk(A_CTRL, 32'h0, "reset_ctrl");
    rd_chk(A_STAT, 32'h0, "reset_stat");
    rd_chk(A_RES,  32'h0, "reset_res");

    // stb held high: ack must alternate 1,0,1,...
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_OPER; sel = 4'hF;
    for (int i = 5; i >= 0; i--) begin
      @(posedge clk); #1;
      ack_pat[i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    check("ack_pulse_pattern", {26'h0, ack_pat}, {26'h0, 6'b101010});

    for (int v = 0; v < 5; v++) begin
      wr(A_OPER, vecs[v].oper);
      wr(A_CTRL, {23'h0, 1'b1, 3'h0, vecs[v].ctrl});
      if (vecs[v].ctrl[4]) begin
        n = 0;
        do begin
          @(posedge clk); #1;
          n++;
        end while (!irq && n < 40);
        check($sformatf("v%0d_irq_latency", v), n, LAT);
      end else begin
        rd_chk(A_STAT, 32'h1, $sformatf("v%0d_busy", v));
        wait_idle($sformatf("v%0d_wait", v));
      end
      rd_chk(A_STAT, 32'h2, $sformatf("v%0d_done", v));
      rd_chk(A_RES, pack_res(vecs[v]), $sformatf("v%0d_res", v));
      @(posedge clk); #1;
      check($sformatf("v%0d_dat_idle", v), dat_o, 32'h0);
      check($sformatf("v%0d_irq", v), {31'h0, irq}, {31'h0, vecs[v].ctrl[4]});
      rd_chk(A_CTRL, {27'h0, vecs[v].ctrl}, $sformatf("v%0d_ctrl_rb", v));
      if (vecs[v].ctrl[4]) begin
        wr(A_STAT, 32'h2, 4'b1110);
        check("w1c_unselected_keeps_irq", {31'h0, irq}, 32'h1);
      end
      wr(A_STAT, 32'h2);
      check($sformatf("v%0d_irq_clear", v), {31'h0, irq}, 32'h0);
      rd_chk(A_STAT, 32'h0, $sformatf("v%0d_stat_clear", v));
    end

    // Overrun: second START and OPER rewrite while busy
    wr(A_OPER, vecs[0].oper);
    wr(A_CTRL, 32'h104);
    wr(A_OPER, 32'hFFFF_FFFF);
    wr(A_CTRL, 32'h104);
    wait_idle("ovr_wait");
    rd_chk(A_STAT, 32'h6, "ovr_stat");
    rd_chk(A_RES, pack_res(vecs[0]), "ovr_res_snapshot");
    rd_chk(A_OPER, 32'hFFFF_FFFF, "ovr_oper_rewritten");
    rd_chk(A_STAT, 32'h6, "ovr_no_restart");
    wr(A_STAT, 32'h4);
    rd_chk(A_STAT, 32'h2, "ovr_w1c");
    wr(A_STAT, 32'h2);

    // Out-of-window access and byte enables
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    rd_chk(BASE + 32'h10, 32'h0, "miss_read");
    rd_chk(A_OPER, 32'hFFFF_FFFF, "miss_oper_unchanged");
    rd_chk(A_CTRL, 32'h04, "miss_ctrl_unchanged");
    wr(A_OPER, 32'h0);
    wr(A_OPER, 32'hFFFF_FFFF, 4'b0010);
    rd_chk(A_OPER, 32'h0000_FF00, "sel_byte1");
    wr(A_CTRL, 32'h100, 4'b0001);
    rd_chk(A_STAT, 32'h0, "start_needs_sel1");

    // Reset mid-RUN aborts with no late completion
    wr(A_OPER, vecs[1].oper);
    wr(A_CTRL, 32'h11E);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    rd_chk(A_STAT, 32'h0, "rst_stat");
    rd_chk(A_RES, 32'h0, "rst_res");
    repeat (3 * LAT) @(posedge clk);
    #1;
    check("rst_irq_late", {31'h0, irq}, 32'h0);
    rd_chk(A_STAT, 32'h0, "rst_stat_late");
    rd_chk(A_RES, 32'h0, "rst_res_late");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
